apb_mem_responder: RTL

APB completer that answers the transfers whose protocol rules the APB checker enforces: it decodes one select, samples setup/access phases, and drives PRDATA, PREADY and PSLVERR back to the requester. It holds a word-addressed register memory and inserts a parameterised number of wait states before each completion. It sits behind one of the four select lines (sel1..sel4) of the APB fabric and is the DUT-side responder for the APB UVM environment.

---
 rtl/apb_mem_responder_if.sv | 13 +
 rtl/apb_mem_responder.sv | 75 +++++++
 2 files changed

// File: rtl/apb_mem_responder_if.sv
// apb_mem_responder_if: APB select/strobe/address/data bundle with completer response signals
interface apb_mem_responder_if;
   logic        sel;
   logic        enable;
   logic        write;
   logic [31:0] addr;
   logic [31:0] data;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;
   modport master (output sel, enable, write, addr, data, input PRDATA, PREADY, PSLVERR);
   modport slave (input sel, enable, write, addr, data, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_mem_responder.sv
// apb_mem_responder: APB completer with word memory and wait states; APB_RESP_ERR_EN enables address-error responses
module apb_mem_responder #(
   parameter int DEPTH       = 16,
   parameter int WAIT_STATES = 1
) (
   input  logic               PCLK,
   input  logic               PRESET,
   apb_mem_responder_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic {IDLE, ACCESS} state_t;
   state_t          state, state_n;
   logic [3:0]      cnt;
   logic            err, wr, setup, done, stall, ready, addr_err, err_in;
   logic [AW-1:0]   widx, idx_in;
   logic [31:0]     rdata;
   logic [31:0]     mem [DEPTH];
   // next state and per-edge transfer decode
   always_comb begin
      setup    = bus.sel & ~bus.enable;
      done     = (state == ACCESS) & bus.sel & bus.enable & (cnt == 4'd0);
      stall    = (state == ACCESS) & bus.sel & bus.enable & (cnt != 4'd0);
      ready    = (state == ACCESS) & (cnt == 4'd0);
      addr_err = (bus.addr[1:0] != 2'b00) | (|bus.addr[31:AW+2]);
      idx_in   = bus.addr[AW+1:2];
      state_n  = setup ? ACCESS : ((state == ACCESS) && (!bus.sel || done)) ? IDLE : state;
   end
`ifdef APB_RESP_ERR_EN
   assign err_in = addr_err;
`else
   logic unused_addr_err;
   assign unused_addr_err = addr_err;
   assign err_in = 1'b0;
`endif
   // state register
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) state <= IDLE;
      else        state <= state_n;
   end
   // setup capture: wait count, error flag, word index, direction and read data
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         cnt   <= '0;
         err   <= 1'b0;
         wr    <= 1'b0;
         widx  <= '0;
         rdata <= '0;
      end else if (setup) begin
         cnt  <= 4'(WAIT_STATES);
         err  <= err_in;
         wr   <= bus.write;
         widx <= idx_in;
         if (!bus.write) rdata <= err_in ? 32'd0 : mem[idx_in];
      end else if (stall) begin
         cnt <= cnt - 4'd1;
      end
   end
   // memory: cleared on reset, written at a clean write completion with the data present then
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (done && wr && !err) begin
         mem[widx] <= bus.data;
      end
   end
   assign bus.PRDATA  = rdata;
   assign bus.PREADY  = ready;
`ifdef APB_RESP_ERR_EN
   assign bus.PSLVERR = ready & err;
`else
   assign bus.PSLVERR = 1'b0;
   logic unused_err;
   assign unused_err = err;
`endif
endmodule
